// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - Shared types, scan-code constants and event helpers for the PS/2 decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  localparam int EV_CODE_W  = 8;
  localparam int EV_BRK_BIT = 8;
  localparam int EV_EXT_BIT = 9;
  localparam int EV_W       = 10;

  localparam logic [7:0] C_E0 = 8'hE0;
  localparam logic [7:0] C_F0 = 8'hF0;
  localparam logic [7:0] C_E1 = 8'hE1;
  localparam logic [7:0] C_AA = 8'hAA;
  localparam logic [7:0] C_FA = 8'hFA;
  localparam logic [7:0] C_EE = 8'hEE;
  localparam logic [7:0] C_FC = 8'hFC;
  localparam logic [7:0] C_FD = 8'hFD;
  localparam logic [7:0] C_OVR0 = 8'h00;
  localparam logic [7:0] C_OVR1 = 8'hFF;

  localparam logic [7:0] MOD_LSHIFT = 8'h12;
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL   = 8'h14;
  localparam logic [7:0] MOD_ALT    = 8'h11;

  // Pause sends E1 followed by seven more bytes before the sequence completes.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic [EV_W-1:0] make_event(input logic ext, input logic brk,
                                                 input logic [7:0] code);
    return {ext, brk, code};
  endfunction

  function automatic logic [3:0] mods_update(input logic [3:0] m, input logic [EV_W-1:0] ev);
    logic [3:0] r;
    logic       ext;
    logic       brk;
    r   = m;
    ext = ev[EV_EXT_BIT];
    brk = ev[EV_BRK_BIT];
    case (ev[EV_CODE_W-1:0])
      MOD_LSHIFT: if (!ext) r[0] = ~brk;
      MOD_RSHIFT: if (!ext) r[1] = ~brk;
      MOD_CTRL:   r[2] = ~brk;
      MOD_ALT:    r[3] = ~brk;
      default:    r = m;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - First-word-fall-through ring-buffer FIFO for decoded key events.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

  // A pop frees the slot the simultaneous push needs, so a full FIFO still accepts it.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & o_full & ~w_do_pop;

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - Set-2 scan-code sequence decoder with event FIFO.
// Optional modifier tracking on the mods output is built when PS2_MODIFIER_EN is defined.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     ev_valid,
  output logic [EV_W-1:0]          ev_data,
  input  logic                     ev_rd,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  output logic                     proto_err,
  output logic                     bat_ok,
  output logic [3:0]               mods
);

  localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e       r_state;
  logic [2:0]       r_skip;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_push;
  logic [EV_W-1:0]  r_ev;
  logic             r_overflow;
  logic             r_proto_err;
  logic             r_bat_ok;

  ps2_state_e       w_state_nx;
  logic [2:0]       w_skip_nx;
  logic             w_push;
  logic [EV_W-1:0]  w_ev;
  logic             w_bat;
  logic             w_perr;
  logic             w_empty;
  logic             w_full;
  logic             w_drop;

  // Next-state decode; a received byte always takes priority over the timeout.
  always_comb begin
    w_state_nx = r_state;
    w_skip_nx  = r_skip;
    w_push     = 1'b0;
    w_ev       = '0;
    w_bat      = 1'b0;
    w_perr     = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          case (rx_data)
            C_E0: w_state_nx = ST_EXT;
            C_F0: w_state_nx = ST_BRK;
            C_E1: begin
              w_state_nx = ST_PAUSE;
              w_skip_nx  = PAUSE_SKIP;
            end
            C_AA: w_bat = 1'b1;
            C_FA, C_EE, C_FC, C_FD: w_state_nx = ST_IDLE;
            C_OVR0, C_OVR1: w_perr = 1'b1;
            default: begin
              w_push = 1'b1;
              w_ev   = make_event(1'b0, 1'b0, rx_data);
            end
          endcase
        end
        ST_EXT: begin
          if (rx_data == C_F0) begin
            w_state_nx = ST_EXT_BRK;
          end else begin
            w_state_nx = ST_IDLE;
            if (rx_data != MOD_LSHIFT && rx_data != MOD_RSHIFT) begin
              w_push = 1'b1;
              w_ev   = make_event(1'b1, 1'b0, rx_data);
            end
          end
        end
        ST_BRK: begin
          w_state_nx = ST_IDLE;
          w_push     = 1'b1;
          w_ev       = make_event(1'b0, 1'b1, rx_data);
        end
        ST_EXT_BRK: begin
          w_state_nx = ST_IDLE;
          if (rx_data != MOD_LSHIFT && rx_data != MOD_RSHIFT) begin
            w_push = 1'b1;
            w_ev   = make_event(1'b1, 1'b1, rx_data);
          end
        end
        ST_PAUSE: begin
          w_skip_nx = r_skip - 1'b1;
          if (r_skip == 3'd1) begin
            w_state_nx = ST_IDLE;
            w_push     = 1'b1;
            w_ev       = make_event(1'b1, 1'b0, C_E1);
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_tmo_cnt == TMO_LAST) begin
      w_state_nx = ST_IDLE;
      w_perr     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_skip      <= '0;
      r_tmo_cnt   <= '0;
      r_push      <= 1'b0;
      r_ev        <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_bat_ok    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_skip      <= w_skip_nx;
      r_push      <= w_push;
      r_ev        <= w_ev;
      r_proto_err <= w_perr;
      r_bat_ok    <= w_bat;
      if (w_drop) r_overflow <= 1'b1;
      if (rx_valid || r_state == ST_IDLE || w_perr) r_tmo_cnt <= '0;
      else                                          r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_wdata (r_ev),
    .i_pop   (ev_rd),
    .o_rdata (ev_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (ev_count),
    .o_drop  (w_drop)
  );

  assign ev_valid  = ~w_empty;
  assign overflow  = r_overflow;
  assign proto_err = r_proto_err;
  assign bat_ok    = r_bat_ok;

`ifdef PS2_MODIFIER_EN
  logic [3:0] r_mods;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_mods <= 4'b0000;
    else if (w_push) r_mods <= mods_update(r_mods, w_ev);
  end

  assign mods = r_mods;
`else
  assign mods = 4'b0000;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - Directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        ev_valid;
  logic [9:0]  ev_data;
  logic        ev_rd;
  logic [3:0]  ev_count;
  logic        overflow;
  logic        proto_err;
  logic        bat_ok;
  logic [3:0]  mods;

  int vectors     = 0;
  int miscompares = 0;
  int perr_pulses = 0;
  int bat_pulses  = 0;
  int perr_base;
  int bat_base;

  ps2_scancode_decoder #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_rd     (ev_rd),
    .ev_count  (ev_count),
    .overflow  (overflow),
    .proto_err (proto_err),
    .bat_ok    (bat_ok),
    .mods      (mods)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (proto_err === 1'b1) perr_pulses++;
    if (bat_ok === 1'b1)    bat_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pop();
    ev_rd = 1'b1;
    @(negedge clk);
    ev_rd = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ev_rd    = 1'b0;
    cycles(2);
    check("rst_ev_valid", 32'(ev_valid), 32'h0);
    check("rst_ev_count", 32'(ev_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check("rst_bat_ok", 32'(bat_ok), 32'h0);
    check("rst_mods", 32'(mods), 32'h0);
    reset = 1'b0;
    cycles(1);

    send(8'h1C);
    check("t1_latency", 32'(ev_valid), 32'h0);
    cycles(1);
    check("t1_valid", 32'(ev_valid), 32'h1);
    check("t1_data", 32'(ev_data), 32'h01C);
    check("t1_count", 32'(ev_count), 32'h1);
    pop();
    check("t1_empty", 32'(ev_valid), 32'h0);

    send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h75);
    cycles(2);
    check("t2_count", 32'(ev_count), 32'h2);
    check("t2_first", 32'(ev_data), 32'h11C);
    pop();
    check("t2_second", 32'(ev_data), 32'h375);
    pop();
    check("t2_drained", 32'(ev_count), 32'h0);

    perr_base = perr_pulses;
    send(8'hE0);
    cycles(TMO + 5);
    check("t3_perr_once", 32'(perr_pulses - perr_base), 32'h1);
    check("t3_no_event", 32'(ev_count), 32'h0);
    send(8'h1C);
    cycles(2);
    check("t3_after_tmo", 32'(ev_data), 32'h01C);
    pop();
    perr_base = perr_pulses;
    send(8'hFF);
    cycles(2);
    check("t3_overrun_perr", 32'(perr_pulses - perr_base), 32'h1);
    check("t3_overrun_noev", 32'(ev_count), 32'h0);
    send(8'hE0); send(8'h12);
    cycles(2);
    check("t3_fake_shift", 32'(ev_count), 32'h0);

    for (int i = 0; i <= DEPTH; i++) send(8'h15 + 8'(i));
    cycles(2);
    check("t4_overflow", 32'(overflow), 32'h1);
    check("t4_count_full", 32'(ev_count), 32'(DEPTH));
    check("t4_head", 32'(ev_data), 32'h015);
    rx_valid = 1'b1;
    rx_data  = 8'h2A;
    @(negedge clk);
    rx_valid = 1'b0;
    ev_rd    = 1'b1;
    @(negedge clk);
    ev_rd    = 1'b0;
    check("t4_full_rdwr_cnt", 32'(ev_count), 32'(DEPTH));
    check("t4_full_rdwr_head", 32'(ev_data), 32'h016);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    check("t4_tail", 32'(ev_data), 32'h02A);
    pop();
    check("t4_drained", 32'(ev_count), 32'h0);
    pop();
    check("t4_pop_empty", 32'(ev_count), 32'h0);
    check("t4_ovf_sticky", 32'(overflow), 32'h1);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    cycles(2);
    check("t5_pause_count", 32'(ev_count), 32'h1);
    check("t5_pause_data", 32'(ev_data), 32'h2E1);
    pop();
    bat_base = bat_pulses;
    send(8'hAA);
    cycles(2);
    check("t5_bat_ok", 32'(bat_pulses - bat_base), 32'h1);
    check("t5_bat_noev", 32'(ev_count), 32'h0);

    send(8'h1D);
    send(8'hE0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check("t6_rst_count", 32'(ev_count), 32'h0);
    check("t6_rst_ovf", 32'(overflow), 32'h0);
    send(8'h1C);
    cycles(2);
    check("t6_idle_after_rst", 32'(ev_data), 32'h01C);
    pop();
    send(8'h12);
`ifdef PS2_MODIFIER_EN
    check("t6_mods_make", 32'(mods), 32'h1);
`else
    check("t6_mods_off", 32'(mods), 32'h0);
`endif
    send(8'hF0); send(8'h12);
    check("t6_mods_break", 32'(mods), 32'h0);
    cycles(2);
    check("t6_mod_events", 32'(ev_count), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
